// File: rtl/io_bus_fabric.sv
// Single-master address-decoding fabric: IDLE -> ACCESS -> RESP handshake to N_SLAVES regions.
// Optional access watchdog enabled by defining BUS_TIMEOUT_EN.
module io_bus_fabric #(
  parameter int                     N_SLAVES    = 4,
  parameter logic [N_SLAVES*32-1:0] BASE_ADDRS  = {32'h0004_0000, 32'h0003_0000,
                                                   32'h0002_0000, 32'h0001_0000},
  parameter int                     REGION_BITS = 16,
  parameter int                     TIMEOUT     = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [31:0]              i_bus_addr,
  input  logic [31:0]              i_bus_wdata,
  input  logic                     i_bus_we,
  input  logic                     i_bus_re,
  output logic [31:0]              o_bus_rdata,
  output logic                     o_bus_ready,
  output logic                     o_bus_err,
  output logic [N_SLAVES-1:0]      o_s_sel,
  output logic [REGION_BITS-1:0]   o_s_addr,
  output logic [31:0]              o_s_wdata,
  output logic                     o_s_we,
  input  logic [N_SLAVES*32-1:0]   i_s_rdata,
  input  logic [N_SLAVES-1:0]      i_s_ready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                   r_state;
  logic [31:0]              r_bus_rdata;
  logic                     r_bus_ready;
  logic                     r_bus_err;
  logic [N_SLAVES-1:0]      r_s_sel;
  logic [REGION_BITS-1:0]   r_s_addr;
  logic [31:0]              r_s_wdata;
  logic                     r_s_we;

  logic [N_SLAVES-1:0]      w_match;
  logic [N_SLAVES-1:0]      w_dec_sel;
  logic                     w_hit;
  logic                     w_req;
  logic                     w_sel_ready;
  logic [31:0]              w_sel_rdata;

`ifdef BUS_TIMEOUT_EN
  logic [7:0]               r_tmo_cnt;
`else
  logic [7:0]               w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT);
`endif

  // Region match per slot; only the bits above the region size take part.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      w_match[i] = ((i_bus_addr >> REGION_BITS) == (BASE_ADDRS[32*i +: 32] >> REGION_BITS));
    end
  end

  // Isolating the lowest set bit gives the lowest-index winner on overlapping bases.
  assign w_dec_sel   = w_match & (~w_match + N_SLAVES'(1));
  assign w_hit       = |w_match;
  assign w_req       = i_bus_re | i_bus_we;
  assign w_sel_ready = |(i_s_ready & r_s_sel);

  // Read data mux from the one-hot selected slave.
  always_comb begin
    w_sel_rdata = 32'h0000_0000;
    for (int i = 0; i < N_SLAVES; i++) begin
      w_sel_rdata = w_sel_rdata | (i_s_rdata[32*i +: 32] & {32{r_s_sel[i]}});
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_bus_rdata <= 32'h0000_0000;
      r_bus_ready <= 1'b0;
      r_bus_err   <= 1'b0;
      r_s_sel     <= '0;
      r_s_addr    <= '0;
      r_s_wdata   <= 32'h0000_0000;
      r_s_we      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      r_tmo_cnt   <= 8'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bus_ready <= 1'b0;
          if (w_req) begin
            r_s_addr  <= i_bus_addr[REGION_BITS-1:0];
            r_s_wdata <= i_bus_wdata;
            r_s_we    <= i_bus_we;
            if (w_hit) begin
              r_s_sel <= w_dec_sel;
              r_state <= ST_ACCESS;
`ifdef BUS_TIMEOUT_EN
              r_tmo_cnt <= 8'd0;
`endif
            end else begin
              r_s_sel     <= '0;
              r_bus_rdata <= 32'h0000_0000;
              r_bus_err   <= 1'b1;
              r_bus_ready <= 1'b1;
              r_state     <= ST_RESP;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (w_sel_ready) begin
            r_bus_rdata <= r_s_we ? 32'h0000_0000 : w_sel_rdata;
            r_bus_err   <= 1'b0;
            r_bus_ready <= 1'b1;
            r_s_sel     <= '0;
            r_state     <= ST_RESP;
`ifdef BUS_TIMEOUT_EN
          end else if (r_tmo_cnt == 8'(TIMEOUT - 1)) begin
            r_bus_rdata <= 32'hDEAD_BEEF;
            r_bus_err   <= 1'b1;
            r_bus_ready <= 1'b1;
            r_s_sel     <= '0;
            r_state     <= ST_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
`else
          end else begin
            r_state <= ST_ACCESS;
`endif
          end
        end
        ST_RESP: begin
          r_bus_ready <= 1'b0;
          r_s_sel     <= '0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_bus_ready <= 1'b0;
          r_s_sel     <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_bus_rdata = r_bus_rdata;
  assign o_bus_ready = r_bus_ready;
  assign o_bus_err   = r_bus_err;
  assign o_s_sel     = r_s_sel;
  assign o_s_addr    = r_s_addr;
  assign o_s_wdata   = r_s_wdata;
  assign o_s_we      = r_s_we;

endmodule

// File: tb/tb_io_bus_fabric.sv
// Directed, table-driven bench for io_bus_fabric, plus hand sequences for back-to-back
// requests and reset during ACCESS. Expected timeout behaviour follows BUS_TIMEOUT_EN.
module tb_io_bus_fabric;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   bus_addr, bus_wdata, bus_rdata, s_wdata;
  logic          bus_we, bus_re, bus_ready, bus_err, s_we;
  logic [3:0]    s_sel, s_ready;
  logic [15:0]   s_addr;
  logic [127:0]  s_rdata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  io_bus_fabric dut (
    .i_clk(clk), .i_rst(rst),
    .i_bus_addr(bus_addr), .i_bus_wdata(bus_wdata), .i_bus_we(bus_we), .i_bus_re(bus_re),
    .o_bus_rdata(bus_rdata), .o_bus_ready(bus_ready), .o_bus_err(bus_err),
    .o_s_sel(s_sel), .o_s_addr(s_addr), .o_s_wdata(s_wdata), .o_s_we(s_we),
    .i_s_rdata(s_rdata), .i_s_ready(s_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    int          slave;   // -1: unmapped
    logic [31:0] srd;     // read data presented by the target slave
    int          rdy_cyc; // cycle at which the target asserts s_ready (held after)
    logic [3:0]  sel;
    logic [15:0] saddr;
    int          lat;     // cycle of bus_ready; 0 means no bus_ready within 100 cycles
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic we,
                              input logic re, input int sl, input logic [31:0] srd,
                              input int rc, input logic [3:0] sel, input logic [15:0] sa,
                              input int lat, input logic [31:0] rd, input logic err);
    vec_t v;
    v.addr = a; v.wdata = wd; v.we = we; v.re = re; v.slave = sl; v.srd = srd;
    v.rdy_cyc = rc; v.sel = sel; v.saddr = sa; v.lat = lat; v.rdata = rd; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_addr = 32'h0; bus_wdata = 32'h0; bus_we = 1'b0; bus_re = 1'b0; s_ready = 4'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int         got;
    int         lim;
    logic [3:0] rmask;
    rmask = (v.slave >= 0) ? 4'(1 << v.slave) : 4'b0000;
    for (int i = 0; i < 4; i++)
      s_rdata[32*i +: 32] = (i == v.slave) ? v.srd : (32'hBAD0_0000 | 32'(i));
    lim = (v.lat == 0) ? 100 : 60;
    @(negedge clk);
    bus_addr = v.addr; bus_wdata = v.wdata; bus_we = v.we; bus_re = v.re;
    s_ready = ~rmask;
    got = 0;
    for (int c = 1; c <= lim && got == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("sel", 32'(s_sel), 32'(v.sel));
        chk("s_addr", 32'(s_addr), 32'(v.saddr));
        chk("s_we", 32'(s_we), 32'(v.we));
        chk("s_wdata", s_wdata, v.wdata);
      end else if (v.lat == 0 || c < v.lat) begin
        chk("hold_sel", 32'(s_sel), 32'(v.sel));
        chk("hold_wdata", s_wdata, v.wdata);
        chk("hold_addr", 32'(s_addr), 32'(v.saddr));
      end
      bus_addr = ~v.addr;
      bus_wdata = ~v.wdata;
      s_ready = (c >= v.rdy_cyc) ? 4'b1111 : ~rmask;
      if (bus_ready) begin
        got = c;
        chk("rdata", bus_rdata, v.rdata);
        chk("err", 32'(bus_err), 32'(v.err));
        chk("resp_sel", 32'(s_sel), 32'h0);
        bus_re = 1'b0; bus_we = 1'b0; s_ready = 4'b0;
      end
    end
    chk("latency", 32'(got), 32'(v.lat));
    if (got != 0) begin
      @(negedge clk);
      chk("pulse_end", 32'(bus_ready), 32'h0);
      chk("rdata_hold", bus_rdata, v.rdata);
      chk("err_hold", 32'(bus_err), 32'(v.err));
    end else begin
      do_reset();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    s_rdata = '0;
    vecs[0] = mk(32'h0002_0010, 32'h0, 1'b0, 1'b1, 1, 32'h1234_5678, 1, 4'b0010, 16'h0010, 2, 32'h1234_5678, 1'b0);
    vecs[1] = mk(32'h0001_0004, 32'h0000_ABCD, 1'b1, 1'b0, 0, 32'hFFFF_FFFF, 3, 4'b0001, 16'h0004, 4, 32'h0, 1'b0);
    vecs[2] = mk(32'h0009_0000, 32'h0, 1'b0, 1'b1, -1, 32'h0, 1, 4'b0000, 16'h0000, 1, 32'h0, 1'b1);
    vecs[3] = mk(32'h0004_0000, 32'h5555_AAAA, 1'b1, 1'b1, 3, 32'h7777_7777, 1, 4'b1000, 16'h0000, 2, 32'h0, 1'b0);
    vecs[4] = mk(32'h0003_FFFC, 32'h0, 1'b0, 1'b1, 2, 32'hCAFE_F00D, 2, 4'b0100, 16'hFFFC, 3, 32'hCAFE_F00D, 1'b0);
    vecs[5] = mk(32'h0004_8000, 32'h0, 1'b0, 1'b1, 3, 32'h0BAD_CAFE, 1, 4'b1000, 16'h8000, 2, 32'h0BAD_CAFE, 1'b0);
    vecs[6] = mk(32'h0000_1234, 32'h0, 1'b0, 1'b1, -1, 32'h0, 1, 4'b0000, 16'h1234, 1, 32'h0, 1'b1);
    vecs[7] = mk(32'h0002_FFFF, 32'h1357_9BDF, 1'b1, 1'b0, 1, 32'h2468_ACE0, 5, 4'b0010, 16'hFFFF, 6, 32'h0, 1'b0);
    vecs[8] = mk(32'h0003_0000, 32'h0, 1'b0, 1'b1, 2, 32'h600D_600D, 15, 4'b0100, 16'h0000, 16, 32'h600D_600D, 1'b0);
`ifdef BUS_TIMEOUT_EN
    vecs[9] = mk(32'h0003_0000, 32'h0, 1'b0, 1'b1, 2, 32'h1111_2222, 1000, 4'b0100, 16'h0000, 16, 32'hDEAD_BEEF, 1'b1);
`else
    vecs[9] = mk(32'h0003_0000, 32'h0, 1'b0, 1'b1, 2, 32'h1111_2222, 1000, 4'b0100, 16'h0000, 0, 32'h0, 1'b0);
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(bus_ready), 32'h0);
    chk("rst_err", 32'(bus_err), 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_sel", 32'(s_sel), 32'h0);
    chk("rst_we", 32'(s_we), 32'h0);

    for (int k = 0; k < 10; k++) run_vec(vecs[k]);

    // Back-to-back: request held through RESP restarts in the following IDLE cycle
    for (int i = 0; i < 4; i++) s_rdata[32*i +: 32] = 32'h1234_5678;
    @(negedge clk);
    bus_addr = 32'h0002_0010; bus_re = 1'b1; s_ready = 4'b1111;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(bus_ready), 32'((c == 2) || (c == 5)));
      if (c == 4) chk("b2b_sel", 32'(s_sel), 32'h2);
      if (c == 5) bus_re = 1'b0;
    end
    s_ready = 4'b0;

    // Reset during ACCESS drops the transaction
    @(negedge clk);
    bus_addr = 32'h0003_0040; bus_wdata = 32'h0000_7777; bus_re = 1'b1; s_ready = 4'b0;
    @(negedge clk);
    chk("mid_sel", 32'(s_sel), 32'h4);
    @(negedge clk);
    rst = 1'b1; bus_re = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_sel", 32'(s_sel), 32'h0);
    chk("mr_addr", 32'(s_addr), 32'h0);
    chk("mr_wdata", s_wdata, 32'h0);
    chk("mr_rdata", bus_rdata, 32'h0);
    chk("mr_ready", 32'(bus_ready), 32'h0);
    chk("mr_err", 32'(bus_err), 32'h0);
    chk("mr_we", 32'(s_we), 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mr_no_ready", 32'(bus_ready), 32'h0);
    end
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/io_bus_fabric.md
IO_BUS_FABRIC -- requirements
Module: io_bus_fabric

Interface
REQ-001 Parameter N_SLAVES, default 4: number of peripheral regions (1..8).
REQ-002 Parameter BASE_ADDRS, default {32'h0004_0000,32'h0003_0000,32'h0002_0000,32'h0001_0000}: packed N_SLAVES*32 bases; slot i at bits [32i+31:32i].
REQ-003 Parameter REGION_BITS, default 16: log2 region size; decode compares addr[31:REGION_BITS] only.
REQ-004 Parameter TIMEOUT, default 15: max ACCESS cycles before abort (2..255).
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 bus_addr  input  32  core request address.
REQ-008 bus_wdata  input  32  core write data.
REQ-009 bus_we  input  1  write request.
REQ-010 bus_re  input  1  read request.
REQ-011 bus_rdata  output  32  registered read data, valid while bus_ready=1.
REQ-012 bus_ready  output  1  one-cycle completion pulse.
REQ-013 bus_err  output  1  error flag, valid while bus_ready=1.
REQ-014 s_sel  output  N_SLAVES  one-hot slave select, held through ACCESS.
REQ-015 s_addr  output  REGION_BITS  latched offset addr[REGION_BITS-1:0].
REQ-016 s_wdata  output  32  latched write data.
REQ-017 s_we  output  1  latched write qualifier, valid with s_sel.
REQ-018 s_rdata  input  N_SLAVES*32  packed slave read data.
REQ-019 s_ready  input  N_SLAVES  per-slave completion.

Function
REQ-020 FSM states IDLE, ACCESS, RESP shall be implemented; only IDLE accepts requests.
REQ-021 IDLE: bus_re|bus_we shall latch addr, wdata and we (we=1 if bus_we, including when both asserted) and decode.
REQ-022 Decode hit: lowest index i with matching base wins; next state ACCESS with s_sel[i]=1.
REQ-023 Decode miss: next state RESP, bus_err=1, bus_rdata=0, no s_sel asserted.
REQ-024 ACCESS: when s_ready of selected slave is 1, capture its s_rdata (0 for writes) into bus_rdata, err=0, next RESP; s_ready of unselected slaves ignored.
REQ-025 RESP: bus_ready=1 for exactly one cycle, s_sel=0, next IDLE.
REQ-026 Minimum latency: request at cycle 0, s_ready=1 at cycle 1 -> bus_ready at cycle 2.
REQ-027 Requests during ACCESS/RESP ignored; core holds request until bus_ready; a request still asserted in the IDLE cycle after RESP starts a new transaction.
REQ-028 Address/wdata changes after latch shall not affect s_addr/s_wdata.
REQ-029 bus_rdata/bus_err hold last value outside RESP.

Reset
REQ-030 rst shall force IDLE, s_sel=0, s_we=0, s_addr=0, s_wdata=0, bus_rdata=0, bus_ready=0, bus_err=0, timeout counter=0, including mid-ACCESS (transaction dropped, no bus_ready).

Configuration
REQ-031 Macro BUS_TIMEOUT_EN defined: counter cleared on ACCESS entry; if TIMEOUT ACCESS cycles elapse without s_ready, next RESP with bus_err=1, bus_rdata=32'hDEAD_BEEF; s_ready in the final counted cycle wins over timeout.
REQ-032 BUS_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely.

Verification
REQ-033 Read 0x0002_0010, slave1 s_ready at cycle 1 with 0x1234_5678 -> s_sel=0010, s_addr=0x0010, bus_ready cycle 2, rdata 0x1234_5678, err 0.
REQ-034 Write 0x0001_0004 data 0xABCD, slave0 ready after 3 cycles -> s_we=1, s_wdata=0xABCD held 3 cycles, single bus_ready pulse.
REQ-035 Read 0x0009_0000 (unmapped) -> no s_sel, bus_ready cycle 1, err 1, rdata 0.
REQ-036 BUS_TIMEOUT_EN, read 0x0003_0000, slave2 never ready -> bus_ready after 15 ACCESS cycles, err 1, rdata 0xDEAD_BEEF; without macro, no bus_ready in 100 cycles.
REQ-037 rst asserted during ACCESS -> next cycle all outputs zero, IDLE, no bus_ready; a new request then completes normally.
REQ-038 bus_re and bus_we both high to 0x0004_0000 -> treated as write, s_sel=1000, s_we=1.
